// File: rtl/stk_pkg.sv
// Shared types for the stack-engine pipeline: engine id, pointer and
// writeback microcode control fields.
package stk_pkg;

  localparam int unsigned ENGS_N  = 4;
  // One spare bit so out-of-range engine ids are representable and detectable.
  localparam int unsigned ENGID_W = 3;

  typedef logic [ENGID_W-1:0] engid_t;
  typedef logic [15:0]        ptr_t;

  // Pointer values travel beside this struct so their width can follow PTR_W.
  typedef struct packed {
    logic   vld;
    engid_t engid;
    logic   set_empty;
    logic   clr_empty;
    logic   head_vld;
    logic   tail_vld;
  } wrbk_uc_t;

  function automatic logic engid_in_range(engid_t id, int unsigned n);
    return 32'(id) < n;
  endfunction

endpackage

// File: rtl/stk_pipe_wrbk_ent.sv
// One engine's state: empty flag plus head/tail pointers, written by the
// WB stage. A simultaneous set and clear leaves the empty flag unchanged.
module stk_pipe_wrbk_ent #(
  parameter int unsigned PTR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             set_empty,
  input  logic             clr_empty,
  input  logic             head_vld,
  input  logic [PTR_W-1:0] head_ptr,
  input  logic             tail_vld,
  input  logic [PTR_W-1:0] tail_ptr,
  output logic             empty,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      empty <= 1'b1;
      head  <= '0;
      tail  <= '0;
    end else if (we) begin
      if (set_empty && !clr_empty) begin
        empty <= 1'b1;
      end else if (clr_empty && !set_empty) begin
        empty <= 1'b0;
      end
      if (head_vld) head <= head_ptr;
      if (tail_vld) tail <= tail_ptr;
    end
  end

endmodule

// File: rtl/stk_pipe_wrbk.sv
// Writeback stage: registers MEM-stage microcode, applies it to a flop-based
// per-engine state table one edge later, and forwards it to the LK-stage read.
module stk_pipe_wrbk #(
  parameter int unsigned ENGS_N = stk_pkg::ENGS_N,
  parameter int unsigned PTR_W  = $bits(stk_pkg::ptr_t)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wrbk_uc_vld_w,
  input  stk_pkg::engid_t      i_wrbk_uc_engid_w,
  input  logic                 i_wrbk_uc_set_empty_w,
  input  logic                 i_wrbk_uc_clr_empty_w,
  input  logic                 i_wrbk_uc_head_vld_w,
  input  logic [PTR_W-1:0]     i_wrbk_uc_head_ptr_w,
  input  logic                 i_wrbk_uc_tail_vld_w,
  input  logic [PTR_W-1:0]     i_wrbk_uc_tail_ptr_w,
  input  stk_pkg::engid_t      i_lk_rd_engid,
  output logic                 o_lk_rd_empty,
  output logic [PTR_W-1:0]     o_lk_rd_head,
  output logic [PTR_W-1:0]     o_lk_rd_tail,
  output logic [ENGS_N-1:0]    o_empty_vec_r,
  output logic                 o_cmt_vld_r,
  output stk_pkg::engid_t      o_cmt_engid_r,
  output logic                 o_err_r
);

  import stk_pkg::*;

  wrbk_uc_t         wb_q;
  logic [PTR_W-1:0] wb_head_q;
  logic [PTR_W-1:0] wb_tail_q;

  logic             wb_ok;
  logic             wb_bad;
  logic             cmt_vld_q;
  engid_t           cmt_engid_q;
  logic             err_q;

  logic [ENGS_N-1:0] empty_tbl;
  logic [PTR_W-1:0]  head_tbl [ENGS_N];
  logic [PTR_W-1:0]  tail_tbl [ENGS_N];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_q      <= '0;
      wb_head_q <= '0;
      wb_tail_q <= '0;
    end else begin
      wb_q.vld       <= i_wrbk_uc_vld_w;
      wb_q.engid     <= i_wrbk_uc_engid_w;
      wb_q.set_empty <= i_wrbk_uc_set_empty_w;
      wb_q.clr_empty <= i_wrbk_uc_clr_empty_w;
      wb_q.head_vld  <= i_wrbk_uc_head_vld_w;
      wb_q.tail_vld  <= i_wrbk_uc_tail_vld_w;
      wb_head_q      <= i_wrbk_uc_head_ptr_w;
      wb_tail_q      <= i_wrbk_uc_tail_ptr_w;
    end
  end

  assign wb_ok  = wb_q.vld && engid_in_range(wb_q.engid, ENGS_N);
  assign wb_bad = wb_q.vld && (!engid_in_range(wb_q.engid, ENGS_N) ||
                               (wb_q.set_empty && wb_q.clr_empty));

  for (genvar g = 0; g < ENGS_N; g++) begin : g_ent
    stk_pipe_wrbk_ent #(
      .PTR_W(PTR_W)
    ) u_ent (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (wb_ok && (32'(wb_q.engid) == g)),
      .set_empty(wb_q.set_empty),
      .clr_empty(wb_q.clr_empty),
      .head_vld (wb_q.head_vld),
      .head_ptr (wb_head_q),
      .tail_vld (wb_q.tail_vld),
      .tail_ptr (wb_tail_q),
      .empty    (empty_tbl[g]),
      .head     (head_tbl[g]),
      .tail     (tail_tbl[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmt_vld_q   <= 1'b0;
      cmt_engid_q <= '0;
      err_q       <= 1'b0;
    end else begin
      cmt_vld_q <= wb_ok;
      if (wb_ok) cmt_engid_q <= wb_q.engid;
      if (wb_bad) err_q <= 1'b1;
    end
  end

  // Table read with per-field bypass from the youngest (WB register) entry.
  always_comb begin
    o_lk_rd_empty = 1'b1;
    o_lk_rd_head  = '0;
    o_lk_rd_tail  = '0;
    for (int unsigned i = 0; i < ENGS_N; i++) begin
      if (32'(i_lk_rd_engid) == i) begin
        o_lk_rd_empty = empty_tbl[i];
        o_lk_rd_head  = head_tbl[i];
        o_lk_rd_tail  = tail_tbl[i];
      end
    end
    if (wb_ok && (wb_q.engid == i_lk_rd_engid)) begin
      if (wb_q.set_empty && !wb_q.clr_empty) begin
        o_lk_rd_empty = 1'b1;
      end else if (wb_q.clr_empty && !wb_q.set_empty) begin
        o_lk_rd_empty = 1'b0;
      end
      if (wb_q.head_vld) o_lk_rd_head = wb_head_q;
      if (wb_q.tail_vld) o_lk_rd_tail = wb_tail_q;
    end
  end

  assign o_empty_vec_r = empty_tbl;
  assign o_cmt_vld_r   = cmt_vld_q;
  assign o_cmt_engid_r = cmt_engid_q;
  assign o_err_r       = err_q;

endmodule

// File: tb/tb_stk_pipe_wrbk.sv
// Directed bench for stk_pipe_wrbk: commit strobes go through a scoreboard
// queue checked by a monitor; LK reads, empty vector and error are checked inline.
module tb_stk_pipe_wrbk;

  import stk_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             uc_vld;
  engid_t           uc_engid;
  logic             uc_set;
  logic             uc_clr;
  logic             uc_hv;
  logic [15:0]      uc_hp;
  logic             uc_tv;
  logic [15:0]      uc_tp;
  engid_t           rd_engid;
  logic             rd_empty;
  logic [15:0]      rd_head;
  logic [15:0]      rd_tail;
  logic [3:0]       empty_vec;
  logic             cmt_vld;
  engid_t           cmt_engid;
  logic             err;

  int checks = 0;
  int errors = 0;
  engid_t exp_cmt[$];

  always #5 clk = ~clk;

  stk_pipe_wrbk dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_wrbk_uc_vld_w      (uc_vld),
    .i_wrbk_uc_engid_w    (uc_engid),
    .i_wrbk_uc_set_empty_w(uc_set),
    .i_wrbk_uc_clr_empty_w(uc_clr),
    .i_wrbk_uc_head_vld_w (uc_hv),
    .i_wrbk_uc_head_ptr_w (uc_hp),
    .i_wrbk_uc_tail_vld_w (uc_tv),
    .i_wrbk_uc_tail_ptr_w (uc_tp),
    .i_lk_rd_engid        (rd_engid),
    .o_lk_rd_empty        (rd_empty),
    .o_lk_rd_head         (rd_head),
    .o_lk_rd_tail         (rd_tail),
    .o_empty_vec_r        (empty_vec),
    .o_cmt_vld_r          (cmt_vld),
    .o_cmt_engid_r        (cmt_engid),
    .o_err_r              (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every commit pulse must match the oldest expected engine.
  always @(negedge clk) begin
    if (cmt_vld === 1'b1) begin
      if (exp_cmt.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmt_unexpected actual=%0d required=none", cmt_engid);
      end else begin
        chk("cmt_engid", 32'(cmt_engid), 32'(exp_cmt.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_uc(input int e, input logic s, input logic c, input logic hv,
                        input logic [15:0] hp, input logic tv, input logic [15:0] tp);
    uc_vld = 1'b1; uc_engid = 3'(e); uc_set = s; uc_clr = c;
    uc_hv = hv; uc_hp = hp; uc_tv = tv; uc_tp = tp;
  endtask

  task automatic idle();
    uc_vld = 1'b0; uc_engid = '0; uc_set = 1'b0; uc_clr = 1'b0;
    uc_hv = 1'b0; uc_hp = '0; uc_tv = 1'b0; uc_tp = '0;
  endtask

  task automatic chk_rd(input string name, input int e, input logic em,
                        input logic [15:0] h, input logic [15:0] t);
    rd_engid = 3'(e);
    #1;
    chk({name, "_empty"}, 32'(rd_empty), 32'(em));
    chk({name, "_head"}, 32'(rd_head), 32'(h));
    chk({name, "_tail"}, 32'(rd_tail), 32'(t));
  endtask

  initial begin
    idle();
    rd_engid = '0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_vec", 32'(empty_vec), 32'h0000_000f);
    chk("rst_err", 32'(err), 32'h0);
    for (int e = 0; e < 4; e++) chk_rd("rst_rd", e, 1'b1, 16'h0000, 16'h0000);

    // Update eng2: bypass in the next cycle, table one cycle later
    set_uc(2, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h0010);
    exp_cmt.push_back(3'd2);
    step(); idle();
    chk_rd("upd_byp", 2, 1'b0, 16'h0010, 16'h0010);
    chk("upd_vec_pre", 32'(empty_vec), 32'h0000_000f);
    step();
    chk("upd_vec", 32'(empty_vec), 32'h0000_000b);
    chk_rd("upd_tbl", 2, 1'b0, 16'h0010, 16'h0010);

    // Back-to-back eng1 tail writes: youngest value forwarded
    set_uc(1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005);
    exp_cmt.push_back(3'd1);
    step();
    chk_rd("b2b_first", 1, 1'b1, 16'h0000, 16'h0005);
    set_uc(1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006);
    exp_cmt.push_back(3'd1);
    step(); idle();
    chk_rd("b2b_second", 1, 1'b1, 16'h0000, 16'h0006);
    step();
    chk_rd("b2b_tbl", 1, 1'b1, 16'h0000, 16'h0006);
    chk("b2b_vec", 32'(empty_vec), 32'h0000_000b);

    // Update eng1 while reading eng2: no bypass onto eng2
    set_uc(1, 1'b0, 1'b0, 1'b1, 16'h0077, 1'b0, 16'h0000);
    exp_cmt.push_back(3'd1);
    step(); idle();
    chk_rd("nomatch", 2, 1'b0, 16'h0010, 16'h0010);
    step();
    chk_rd("nomatch_eng1", 1, 1'b1, 16'h0077, 16'h0006);

    // Conflicting set+clr on eng0: empty holds, head applies, error sticks
    set_uc(0, 1'b1, 1'b1, 1'b1, 16'h00a0, 1'b0, 16'h0000);
    exp_cmt.push_back(3'd0);
    step(); idle();
    chk_rd("cfl_byp", 0, 1'b1, 16'h00a0, 16'h0000);
    chk("cfl_err_pre", 32'(err), 32'h0);
    step();
    chk("cfl_err", 32'(err), 32'h1);
    chk_rd("cfl_tbl", 0, 1'b1, 16'h00a0, 16'h0000);
    chk("cfl_vec", 32'(empty_vec), 32'h0000_000b);
    repeat (3) step();
    chk("cfl_err_sticky", 32'(err), 32'h1);

    // Reset while an eng3 update sits in the WB register: it is discarded
    set_uc(3, 1'b0, 1'b1, 1'b1, 16'h0033, 1'b1, 16'h0044);
    step(); idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rmid_vec", 32'(empty_vec), 32'h0000_000f);
    chk("rmid_err", 32'(err), 32'h0);
    chk_rd("rmid_eng3", 3, 1'b1, 16'h0000, 16'h0000);
    chk_rd("rmid_eng0", 0, 1'b1, 16'h0000, 16'h0000);

    // First valid input in the cycle after rst_n rises
    set_uc(0, 1'b0, 1'b1, 1'b1, 16'h0011, 1'b0, 16'h0000);
    exp_cmt.push_back(3'd0);
    step(); idle();
    chk_rd("first_byp", 0, 1'b0, 16'h0011, 16'h0000);
    step();
    chk("first_vec", 32'(empty_vec), 32'h0000_000e);

    // Out-of-range engine id: dropped, error set, no commit
    set_uc(5, 1'b0, 1'b1, 1'b1, 16'h0099, 1'b0, 16'h0000);
    step(); idle();
    chk_rd("oor_alias_byp", 1, 1'b1, 16'h0000, 16'h0000);
    step();
    chk("oor_err", 32'(err), 32'h1);
    chk("oor_vec", 32'(empty_vec), 32'h0000_000e);
    chk_rd("oor_alias_tbl", 1, 1'b1, 16'h0000, 16'h0000);

    repeat (3) step();
    chk("cmt_drained", 32'(exp_cmt.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stk_pipe_wrbk.md
STK_PIPE_WRBK -- requirements
Module: stk_pipe_wrbk

Interface
REQ-001 SHALL take parameter ENGS_N, default stk_pkg::ENGS_N (4): number of engines (queues) whose state is held.
REQ-002 SHALL take parameter PTR_W, default $bits(stk_pkg::ptr_t) (16): width of the head and tail pointers.
REQ-003 SHALL have clk, input, 1: sole clock.
REQ-004 SHALL have rst_n, input, 1: reset; synchronous, active-low.
REQ-005 SHALL have i_wrbk_uc_vld_w, input, 1: writeback microcode valid from the MEM stage.
REQ-006 SHALL have i_wrbk_uc_engid_w, input, engid_t: target engine.
REQ-007 SHALL have i_wrbk_uc_set_empty_w and i_wrbk_uc_clr_empty_w, input, 1 each: empty-flag set and clear commands.
REQ-008 SHALL have i_wrbk_uc_head_vld_w / i_wrbk_uc_head_ptr_w, input, 1 / PTR_W: head-pointer write enable and value.
REQ-009 SHALL have i_wrbk_uc_tail_vld_w / i_wrbk_uc_tail_ptr_w, input, 1 / PTR_W: tail-pointer write enable and value.
REQ-010 SHALL have i_lk_rd_engid, input, engid_t: LK-stage state read address.
REQ-011 SHALL have o_lk_rd_empty / o_lk_rd_head / o_lk_rd_tail, output, 1 / PTR_W / PTR_W: forwarded state of engine i_lk_rd_engid.
REQ-012 SHALL have o_empty_vec_r, output, ENGS_N: registered per-engine empty flags.
REQ-013 SHALL have o_cmt_vld_r / o_cmt_engid_r, output, 1 / engid_t: commit strobe and engine, one per applied microcode.
REQ-014 SHALL have o_err_r, output, 1: sticky protocol error flag.

Function
REQ-015 SHALL register all i_wrbk_uc_* inputs into a single WB pipeline register (vld, engid, cmds, ptrs) every cycle.
REQ-016 SHALL apply a valid WB register entry to the state table at the next clock edge; the table is updated 2 edges after the _w input is presented.
REQ-017 SHALL, on apply, write head only when head_vld=1 and tail only when tail_vld=1; unselected fields hold.
REQ-018 SHALL set empty on set_empty=1 and clear it on clr_empty=1.
REQ-019 SHALL treat set_empty=1 with clr_empty=1 as illegal: the empty flag holds, head/tail updates still apply, and o_err_r sets.
REQ-020 SHALL set o_err_r when i_wrbk_uc_engid_w >= ENGS_N with vld=1; that entry is dropped (no table write, no commit strobe).
REQ-021 SHALL make o_err_r sticky until reset.
REQ-022 SHALL drive o_lk_rd_* combinationally from the table, with per-field bypass from a valid WB register entry whose engid equals i_lk_rd_engid.
REQ-023 SHALL make the LK stage see the update in the cycle after the _w input is presented.
REQ-024 SHALL pulse o_cmt_vld_r for exactly one cycle, in the cycle following each apply, with o_cmt_engid_r = applied engid.
REQ-025 SHALL update o_empty_vec_r in the same edge as the table, so the vector equals the table empty flags.
REQ-026 SHALL apply back-to-back microcodes to the same engine (one per cycle) in order, without loss.
REQ-027 SHALL forward the youngest (WB register) value on back-to-back same-engine updates.
REQ-028 SHALL drive o_lk_rd_* as pure table contents when vld=0 in the WB register; engid is ignored then.

Reset
REQ-029 SHALL, with rst_n=0 at an edge, clear WB vld, o_cmt_vld_r and o_err_r, and set o_cmt_engid_r=0.
REQ-030 SHALL, on reset, set all table empty flags=1 (o_empty_vec_r all ones) and all head/tail=0.
REQ-031 SHALL discard any in-flight WB entry on reset mid-operation; it is never applied.
REQ-032 SHALL accept the first valid input in the cycle after rst_n rises.

Structure
REQ-033 SHALL take engid_t, ptr_t and ENGS_N from stk_pkg, adding a wrbk_uc_t struct there.
REQ-034 SHALL hold the table in flops, not SRAM, since full-vector empty output and same-cycle bypass are required.
REQ-035 SHALL place the per-engine entry (empty/head/tail flops with write logic) in one sub-module, stk_pipe_wrbk_ent, instantiated ENGS_N times.

Verification
REQ-036 SHALL cover reset: after reset, o_empty_vec_r=4'b1111, reads of engine 0-3 give head=tail=0, o_err_r=0.
REQ-037 SHALL cover update: eng2, clr_empty, head=0x0010, tail=0x0010 -> next cycle read eng2 gives empty=0, head=tail=0x0010; o_cmt_vld_r pulses with engid=2; vector becomes 4'b1011.
REQ-038 SHALL cover back-to-back: eng1 tail=0x0005 then eng1 tail=0x0006 -> read eng1 gives 0x0005 then 0x0006; final table tail=0x0006; two commit pulses.
REQ-039 SHALL cover conflict: eng0 set+clr empty with head=0x00A0 -> empty unchanged (1), head=0x00A0, o_err_r=1 and stays 1.
REQ-040 SHALL cover reset mid-operation: valid eng3 update, then rst_n=0 the next cycle -> eng3 stays empty=1, head=0, with no commit pulse.
REQ-041 SHALL cover a non-matching bypass: update eng1 while reading eng2 -> eng2 returns table value, unaffected.
